// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Misses stall the pipeline while whole lines move to and from data memory.
module dcache_ctrl #(
   parameter int SETS      = 32,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [31:0]          addr_i,
   input  logic [31:0]          wdata_i,
   output logic [31:0]          data_o,
   output logic                 stall_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_wdata_o,
   input  logic                 mem_ack_i,
   input  logic [LINE_BITS-1:0] mem_rdata_i
);
   localparam int OFF_W  = $clog2(LINE_BITS / 8);
   localparam int WORD_W = OFF_W - 2;
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = 32 - OFF_W - IDX_W;
   localparam int LA_W   = 32 - OFF_W;

   typedef enum logic [1:0] {IDLE, WB, FETCH, DONE} state_t;

   state_t                 state_q, state_d;
   logic [TAG_W-1:0]       tag_q  [SETS];
   logic [LINE_BITS-1:0]   data_q [SETS];
   logic [SETS-1:0]        valid_q, dirty_q;
   logic [LA_W-1:0]        miss_line_q;

   logic [IDX_W-1:0]       idx, fill_idx;
   logic [TAG_W-1:0]       tag, fill_tag;
   logic [WORD_W+4:0]      sel;
   logic                   lookup, hit, launch, victim_dirty, fill;
   logic                   req_d, we_d;
   logic [31:0]            addr_d;
   logic [LINE_BITS-1:0]   wdata_d;
   logic [1:0]             unused_addr;

   assign unused_addr  = addr_i[1:0];
   assign idx          = addr_i[OFF_W +: IDX_W];
   assign tag          = addr_i[31 -: TAG_W];
   assign sel          = {addr_i[2 +: WORD_W], 5'b0};
   assign fill_idx     = miss_line_q[IDX_W-1:0];
   assign fill_tag     = miss_line_q[LA_W-1 -: TAG_W];

   assign lookup       = (state_q == IDLE) || (state_q == DONE);
   assign hit          = lookup && req_i && valid_q[idx] && (tag_q[idx] == tag);
   assign launch       = (state_q == IDLE) && req_i && !hit;
   assign victim_dirty = valid_q[idx] && dirty_q[idx];
   assign fill         = (state_q == FETCH) && mem_ack_i;

   // State and registered memory-side outputs
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         miss_line_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_o   <= req_d;
         mem_we_o    <= we_d;
         mem_addr_o  <= addr_d;
         mem_wdata_o <= wdata_d;
         if (launch) miss_line_q <= addr_i[31:OFF_W];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (launch) state_d = victim_dirty ? WB : FETCH;
         WB:      if (mem_ack_i) state_d = FETCH;
         FETCH:   if (mem_ack_i) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall_o = req_i && !hit;
      data_o  = hit ? data_q[idx][sel +: 32] : 32'h0;
      req_d   = mem_req_o;
      we_d    = mem_we_o;
      addr_d  = mem_addr_o;
      wdata_d = mem_wdata_o;
      case (state_q)
         IDLE: if (launch) begin
            req_d = 1'b1;
            we_d  = victim_dirty;
            if (victim_dirty) begin
               addr_d  = {tag_q[idx], idx, {OFF_W{1'b0}}};
               wdata_d = data_q[idx];
            end else begin
               addr_d  = {addr_i[31:OFF_W], {OFF_W{1'b0}}};
            end
         end
         // Request stays up across the write-back/fetch boundary.
         WB: if (mem_ack_i) begin
            we_d   = 1'b0;
            addr_d = {miss_line_q, {OFF_W{1'b0}}};
         end
         FETCH: if (mem_ack_i) req_d = 1'b0;
         default: ;
      endcase
   end

   // Tag and data arrays carry no reset; valid qualifies them.
   always_ff @(posedge clk_i) begin
      if (fill) begin
         data_q[fill_idx] <= mem_rdata_i;
         tag_q[fill_idx]  <= fill_tag;
      end else if (hit && we_i) begin
         data_q[idx][sel +: 32] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill) begin
         valid_q[fill_idx] <= 1'b1;
         dirty_q[fill_idx] <= 1'b0;
      end else if (hit && we_i) begin
         dirty_q[idx] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed vector table, multi-cycle corner sequences,
// and random traffic checked against a word-level memory model.
module tb_dcache_ctrl;
   logic         clk = 1'b0;
   logic         rst_i, req_i, we_i;
   logic [31:0]  addr_i, wdata_i, data_o;
   logic         stall_o, mem_req_o, mem_we_o, mem_ack;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o, mem_rdata;

   always #5 clk = ~clk;

   dcache_ctrl dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .data_o(data_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
   );

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Off-chip memory: untouched lines hold a pattern derived from the address.
   logic [255:0] memory [logic [26:0]];
   logic         log_we   [$];
   logic [31:0]  log_addr [$];
   logic [255:0] log_line [$];
   int           lat = 4;

   function automatic logic [31:0] iw(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E3779B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [255:0] mem_line(input logic [26:0] la);
      logic [255:0] l;
      if (memory.exists(la)) return memory[la];
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = iw({la, 5'b0} + 32'(w * 4));
      return l;
   endfunction

   // Acks the outstanding request in the lat-th cycle it has been high.
   initial begin
      int rcnt;
      rcnt = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_ack) begin mem_ack = 1'b0; rcnt = 0; end
         if (!rst_i || !mem_req_o) rcnt = 0;
         else begin
            rcnt++;
            if (rcnt >= lat) begin
               mem_ack = 1'b1;
               log_we.push_back(mem_we_o);
               log_addr.push_back(mem_addr_o);
               log_line.push_back(mem_wdata_o);
               if (mem_we_o) memory[mem_addr_o[31:5]] = mem_wdata_o;
               else mem_rdata = mem_line(mem_addr_o[31:5]);
            end
         end
      end
   end

   // Reference: architectural word contents plus per-set residency for timing.
   logic [31:0] truth [logic [29:0]];
   bit          mv [32];
   logic [21:0] mt [32];
   bit          md [32];

   function automatic int model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input int l, output logic [31:0] expd);
      int i, st;
      i = int'(a[9:5]);
      expd = truth.exists(a[31:2]) ? truth[a[31:2]] : iw(a);
      if (we) truth[a[31:2]] = wd;
      if (mv[i] && mt[i] == a[31:10]) st = 0;
      else begin
         st = (mv[i] && md[i]) ? 2 * l + 1 : l + 1;
         mv[i] = 1'b1;
         mt[i] = a[31:10];
         md[i] = 1'b0;
      end
      if (we) md[i] = 1'b1;
      return st;
   endfunction

   // Called just after a rising edge; returns after the completing edge.
   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output int st, output int rc, output logic [31:0] rd, output logic tmo);
      req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
      st = 0; rc = 0; rd = '0; tmo = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (mem_req_o) rc++;
         if (!stall_o) begin rd = data_o; tmo = 1'b0; break; end
         st++;
      end
      @(posedge clk); #1;
      req_i = 1'b0; we_i = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      int          stall;
      logic [31:0] data;
   } vec_t;

   initial begin
      vec_t        tbl [9];
      int          st, rc, es;
      logic [31:0] rd, expd, a, wd;
      logic        tmo, we;
      logic        exp_we [7];
      logic [31:0] exp_ad [7];

      tbl[0] = '{1'b0, 32'h0000_0040, 32'h0,          5, iw(32'h40)};
      tbl[1] = '{1'b0, 32'h0000_0044, 32'h0,          0, iw(32'h44)};
      tbl[2] = '{1'b1, 32'h0000_0048, 32'hDEAD_BEEF,  0, 32'h0};
      tbl[3] = '{1'b0, 32'h0000_0048, 32'h0,          0, 32'hDEAD_BEEF};
      tbl[4] = '{1'b0, 32'h0000_0448, 32'h0,          9, iw(32'h448)};
      tbl[5] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D,  5, 32'h0};
      tbl[6] = '{1'b0, 32'h0000_1000, 32'h0,          0, 32'hCAFE_F00D};
      tbl[7] = '{1'b0, 32'h0000_2004, 32'h0,          9, iw(32'h2004)};
      tbl[8] = '{1'b0, 32'h0000_1000, 32'h0,          5, 32'hCAFE_F00D};
      exp_we = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_ad = '{32'h40, 32'h40, 32'h440, 32'h1000, 32'h1000, 32'h2000, 32'h1000};

      rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_stall", stall_o, 0);
      chk("reset_data", data_o, 0);
      chk("reset_mem_req", mem_req_o, 0);
      chk("reset_mem_we", mem_we_o, 0);
      chk("reset_mem_addr", mem_addr_o, 0);
      chk("reset_mem_wdata", mem_wdata_o[63:0], 0);
      rst_i = 1'b1;
      @(posedge clk); #1;

      lat = 4;
      for (int i = 0; i < 9; i++) begin
         access(tbl[i].we, tbl[i].addr, tbl[i].wd, st, rc, rd, tmo);
         chk($sformatf("vec%0d_timeout", i), tmo, 0);
         chk($sformatf("vec%0d_stall", i), st, tbl[i].stall);
         chk($sformatf("vec%0d_req_cycles", i), rc, tbl[i].stall == 0 ? 0 : tbl[i].stall - 1);
         if (!tbl[i].we) chk($sformatf("vec%0d_data", i), rd, tbl[i].data);
         else truth[tbl[i].addr[31:2]] = tbl[i].wd;
      end

      chk("xfer_count", log_we.size(), 7);
      for (int k = 0; k < 7 && k < log_we.size(); k++) begin
         chk($sformatf("xfer%0d_we", k), log_we[k], exp_we[k]);
         chk($sformatf("xfer%0d_addr", k), log_addr[k], exp_ad[k]);
      end
      if (log_we.size() >= 5) begin
         chk("wb_line40_word2", log_line[1][95:64], 32'hDEAD_BEEF);
         chk("wb_line40_word0", log_line[1][31:0], iw(32'h40));
         chk("wb_line1000_word0", log_line[4][31:0], 32'hCAFE_F00D);
      end

      // Request withdrawn mid-miss: the fill still lands.
      log_we.delete(); log_addr.delete(); log_line.delete();
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0080;
      @(negedge clk);
      chk("drop_miss_stall", stall_o, 1);
      @(posedge clk); #1;
      req_i = 1'b0;
      @(negedge clk);
      chk("drop_stall_low", stall_o, 0);
      chk("drop_data_zero", data_o, 0);
      chk("drop_fill_busy", mem_req_o, 1);
      repeat (lat + 2) @(posedge clk);
      #1;
      access(1'b0, 32'h0000_0084, 32'h0, st, rc, rd, tmo);
      chk("drop_rehit_stall", st, 0);
      chk("drop_rehit_data", rd, iw(32'h84));
      chk("drop_one_fetch", log_we.size(), 1);

      // Reset while a fetch is outstanding.
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_3000;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_req_before", mem_req_o, 1);
      rst_i = 1'b0;
      #1;
      chk("rst_mid_req_async", mem_req_o, 0);
      chk("rst_mid_addr_async", mem_addr_o, 0);
      req_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b1;
      @(posedge clk); #1;
      for (int s = 0; s < 32; s++) begin mv[s] = 1'b0; md[s] = 1'b0; end
      es = model(1'b0, 32'h0000_3000, 32'h0, lat, expd);
      access(1'b0, 32'h0000_3000, 32'h0, st, rc, rd, tmo);
      chk("rst_refetch_stall", st, 5);
      chk("rst_refetch_data", rd, expd);
      es = model(1'b0, 32'h0000_0448, 32'h0, lat, expd);
      access(1'b0, 32'h0000_0448, 32'h0, st, rc, rd, tmo);
      chk("rst_invalidated_stall", st, es);
      chk("rst_invalidated_data", rd, expd);

      for (int n = 0; n < 300; n++) begin
         lat = $urandom_range(2, 5);
         if ($urandom_range(0, 5) == 0) begin
            @(negedge clk);
            chk("rnd_idle_stall", stall_o, 0);
            chk("rnd_idle_data", data_o, 0);
            @(posedge clk); #1;
         end
         a  = {20'h0, 12'($urandom)};
         we = 1'($urandom);
         wd = $urandom;
         es = model(we, a, wd, lat, expd);
         access(we, a, wd, st, rc, rd, tmo);
         chk($sformatf("rnd%0d_timeout", n), tmo, 0);
         chk($sformatf("rnd%0d_stall a=%0h", n, a), st, es);
         chk($sformatf("rnd%0d_req_cycles", n), rc, es == 0 ? 0 : es - 1);
         if (!we) chk($sformatf("rnd%0d_data a=%0h", n, a), rd, expd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
